// File: rtl/fc_pkg.sv
// Shared types and constants for the fully-connected layer feeder.
package fc_pkg;

    localparam int FC_DATA_WIDTH = 32;

    // Sequencer states: idle, per-neuron clear, element feed, final result cycle
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_FEED  = 2'd2,
        ST_LAST  = 2'd3
    } fc_state_e;

    // Address/index width helper that never returns zero
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fc_addr_gen.sv
// Element (k), neuron (j) and memory address counters for fc_feeder.
// Addresses are registered and hold the value presented to the memories.
// The weight address is a running counter: it advances once per issued
// fetch, so row-major j*N_IN+k falls out without a multiplier.
module fc_addr_gen
    import fc_pkg::*;
#(
    parameter int N_IN  = 16,
    parameter int N_OUT = 8,
    parameter int IN_AW = clog2_min1(N_IN),
    parameter int W_AW  = clog2_min1(N_IN * N_OUT),
    parameter int IDX_W = clog2_min1(N_OUT)
) (
    input  logic             clk,
    input  logic             rst,
    input  fc_state_e        state_i,
    output logic [IN_AW-1:0] in_addr_o,
    output logic [W_AW-1:0]  w_addr_o,
    output logic [IDX_W-1:0] j_o,
    output logic             k_last_o,
    output logic             j_last_o
);

    // True when CLEAR is followed by a FEED cycle that itself issues a fetch
    localparam bit MULTI = (N_IN > 1);

    logic [IN_AW-1:0] k_q, k_d;
    logic [IN_AW-1:0] in_addr_q, in_addr_d;
    logic [W_AW-1:0]  w_addr_q, w_addr_d;
    logic [IDX_W-1:0] j_q, j_d;
    logic             k_more_s;

    assign k_last_o  = (32'(k_q) == 32'(N_IN - 1));
    assign j_last_o  = (32'(j_q) == 32'(N_OUT - 1));
    // Element k+1 is fetched in this FEED cycle and k+2 will be fetched next
    assign k_more_s  = ((32'(k_q) + 32'd2) < 32'(N_IN));
    assign in_addr_o = in_addr_q;
    assign w_addr_o  = w_addr_q;
    assign j_o       = j_q;

    // Counter next-state: advance only between two fetch-issuing cycles
    always_comb begin
        k_d       = k_q;
        j_d       = j_q;
        in_addr_d = in_addr_q;
        w_addr_d  = w_addr_q;
        case (state_i)
            ST_CLEAR: begin
                k_d = '0;
                if (MULTI) begin
                    in_addr_d = in_addr_q + IN_AW'(1'b1);
                    w_addr_d  = w_addr_q + W_AW'(1'b1);
                end else begin
                    in_addr_d = in_addr_q;
                    w_addr_d  = w_addr_q;
                end
            end
            ST_FEED: begin
                if (k_last_o) begin
                    k_d       = '0;
                    in_addr_d = '0;
                    if (j_last_o) begin
                        j_d      = '0;
                        w_addr_d = '0;
                    end else begin
                        j_d      = j_q + IDX_W'(1'b1);
                        w_addr_d = w_addr_q + W_AW'(1'b1);
                    end
                end else begin
                    k_d = k_q + IN_AW'(1'b1);
                    if (k_more_s) begin
                        in_addr_d = in_addr_q + IN_AW'(1'b1);
                        w_addr_d  = w_addr_q + W_AW'(1'b1);
                    end else begin
                        in_addr_d = in_addr_q;
                        w_addr_d  = w_addr_q;
                    end
                end
            end
            ST_IDLE, ST_LAST: begin
                k_d       = '0;
                j_d       = '0;
                in_addr_d = '0;
                w_addr_d  = '0;
            end
            default: begin
                k_d       = '0;
                j_d       = '0;
                in_addr_d = '0;
                w_addr_d  = '0;
            end
        endcase
    end

    // Counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            k_q       <= '0;
            j_q       <= '0;
            in_addr_q <= '0;
            w_addr_q  <= '0;
        end else begin
            k_q       <= k_d;
            j_q       <= j_d;
            in_addr_q <= in_addr_d;
            w_addr_q  <= w_addr_d;
        end
    end

endmodule

// File: rtl/fc_feeder.sv
// Layer sequencer for one fully-connected PE: fetches activation/weight
// pairs, streams them into the PE, clears it between neurons and strobes
// each neuron's accumulated sum out as a one-cycle result.
module fc_feeder
    import fc_pkg::*;
#(
    parameter int DATA_WIDTH  = FC_DATA_WIDTH,
    parameter int N_IN        = 16,
    parameter int N_OUT       = 8,
    parameter int IN_AW       = clog2_min1(N_IN),
    parameter int W_AW        = clog2_min1(N_IN * N_OUT),
    localparam int IDX_W      = clog2_min1(N_OUT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [IN_AW-1:0]      in_addr,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [W_AW-1:0]       w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic [DATA_WIDTH-1:0] input_fc,
    output logic [DATA_WIDTH-1:0] iweight_FC,
    output logic                  start_newcol,
    input  logic [DATA_WIDTH-1:0] output_fc,
    output logic                  res_valid,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic [IDX_W-1:0]      res_idx
);

    fc_state_e        state_q, state_d;
    logic             k_last_s;
    logic             j_last_s;
    logic [IDX_W-1:0] j_s;
    logic             res_valid_q, res_valid_d;
    logic [IDX_W-1:0] res_idx_q, res_idx_d;
    logic             feeding_s;

    fc_addr_gen #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT),
        .IN_AW (IN_AW),
        .W_AW  (W_AW),
        .IDX_W (IDX_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .state_i   (state_q),
        .in_addr_o (in_addr),
        .w_addr_o  (w_addr),
        .j_o       (j_s),
        .k_last_o  (k_last_s),
        .j_last_o  (j_last_s)
    );

    assign feeding_s = (state_q == ST_FEED);

    // Next-state logic for the layer sequence
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CLEAR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: state_d = ST_FEED;
            ST_FEED: begin
                if (k_last_s) begin
                    if (j_last_s) begin
                        state_d = ST_LAST;
                    end else begin
                        state_d = ST_CLEAR;
                    end
                end else begin
                    state_d = ST_FEED;
                end
            end
            ST_LAST: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The PE result is complete in the cycle after a neuron's last element
    always_comb begin
        res_valid_d = feeding_s && k_last_s;
        if (res_valid_d) begin
            res_idx_d = j_s;
        end else begin
            res_idx_d = '0;
        end
    end

    // Result strobe and neuron index registers
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_q <= 1'b0;
            res_idx_q   <= '0;
        end else begin
            res_valid_q <= res_valid_d;
            res_idx_q   <= res_idx_d;
        end
    end

    // Data words pass straight through during FEED; the PE sees zeros otherwise
    assign input_fc     = feeding_s ? in_data : '0;
    assign iweight_FC   = feeding_s ? w_data : '0;
    assign start_newcol = !feeding_s;
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_LAST);
    assign res_valid    = res_valid_q;
    assign res_idx      = res_idx_q;
    // The PE clears only at the end of the capture cycle, so output_fc is live here
    assign res_data     = res_valid_q ? output_fc : '0;

endmodule

// File: tb/tb_fc_feeder.sv
// Scoreboard bench for fc_feeder with memory models and a behavioural fp32 PE.
module tb_fc_feeder;

    localparam int NI    = 4;
    localparam int NO    = 2;
    localparam int DW    = 32;
    localparam int IN_AW = 2;
    localparam int W_AW  = 3;
    localparam int IDX_W = 1;
    localparam int T     = NO * (NI + 1);

    typedef struct {
        int          idx;
        logic [31:0] data;
        longint      cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             busy, done, start_newcol, res_valid;
    logic [IN_AW-1:0] in_addr;
    logic [W_AW-1:0]  w_addr;
    logic [DW-1:0]    in_data = '0;
    logic [DW-1:0]    w_data = '0;
    logic [DW-1:0]    input_fc, iweight_FC, output_fc, res_data;
    logic [IDX_W-1:0] res_idx;
    logic [DW-1:0]    acc_q = '0;

    logic [DW-1:0]    in_mem [NI];
    logic [DW-1:0]    w_mem  [NI*NO];

    longint cyc = 0;
    longint base = -1000;
    bit     pass_on = 1'b0;
    bit     mon_en = 1'b0;
    int     checks = 0;
    int     errors = 0;
    exp_t   exp_q[$];

    fc_feeder #(.DATA_WIDTH(DW), .N_IN(NI), .N_OUT(NO), .IN_AW(IN_AW), .W_AW(W_AW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .in_addr(in_addr), .in_data(in_data), .w_addr(w_addr), .w_data(w_data),
        .input_fc(input_fc), .iweight_FC(iweight_FC), .start_newcol(start_newcol),
        .output_fc(output_fc), .res_valid(res_valid), .res_data(res_data), .res_idx(res_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic real f2r(input logic [31:0] b);
        int  ex;
        real r;
        ex = int'(b[30:23]);
        if (ex == 0) return 0.0;
        r = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** (ex - 127));
        return b[31] ? -r : r;
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        int          ex;
        if (r == 0.0) return 32'h0;
        d  = $realtobits(r);
        ex = int'(d[62:52]) - 1023 + 127;
        return {d[63], ex[7:0], d[51:29]};
    endfunction

    // Memories with one-cycle read latency
    always @(posedge clk) begin
        in_data <= in_mem[in_addr];
        w_data  <= w_mem[w_addr];
    end

    // Behavioural PE: registered fp32 multiply-accumulate with clear
    always @(posedge clk) begin
        if (start_newcol) acc_q <= 32'h0;
        else acc_q <= r2f(f2r(acc_q) + f2r(input_fc) * f2r(iweight_FC));
    end
    assign output_fc = acc_q;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h cycle=%0d", nm, act, exp_v, cyc);
        end
    endtask

    task automatic reset_check();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_snc", 64'(start_newcol), 64'd1);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_res_data", 64'(res_data), 64'd0);
        chk("rst_res_idx", 64'(res_idx), 64'd0);
        chk("rst_in_addr", 64'(in_addr), 64'd0);
        chk("rst_w_addr", 64'(w_addr), 64'd0);
        chk("rst_input_fc", 64'(input_fc), 64'd0);
        chk("rst_iweight", 64'(iweight_FC), 64'd0);
    endtask

    // Per-cycle timing model and result monitor
    task automatic monitor_cycle();
        longint t;
        int     p, j;
        exp_t   e;
        t = cyc - base;
        if (pass_on && t >= 0 && t < T) begin
            p = int'(t % (NI + 1));
            j = int'(t / (NI + 1));
            chk("busy", 64'(busy), 64'd1);
            chk("done", 64'(done), 64'd0);
            chk("start_newcol", 64'(start_newcol), 64'(p == 0));
            chk("res_valid", 64'(res_valid), 64'(p == 0 && j > 0));
            if (p < NI) begin
                chk("w_addr", 64'(w_addr), 64'(j * NI + p));
                chk("in_addr", 64'(in_addr), 64'(p));
            end
            if (p >= 1) begin
                chk("input_fc", 64'(input_fc), 64'(in_mem[p-1]));
                chk("iweight_FC", 64'(iweight_FC), 64'(w_mem[j*NI+p-1]));
            end else begin
                chk("input_fc_clr", 64'(input_fc), 64'd0);
                chk("iweight_clr", 64'(iweight_FC), 64'd0);
            end
        end else if (pass_on && t == T) begin
            chk("last_busy", 64'(busy), 64'd1);
            chk("last_done", 64'(done), 64'd1);
            chk("last_snc", 64'(start_newcol), 64'd1);
            chk("last_res_valid", 64'(res_valid), 64'd1);
            chk("last_input_fc", 64'(input_fc), 64'd0);
        end else begin
            chk("idle_busy", 64'(busy), 64'd0);
            chk("idle_done", 64'(done), 64'd0);
            chk("idle_snc", 64'(start_newcol), 64'd1);
            chk("idle_res_valid", 64'(res_valid), 64'd0);
            chk("idle_input_fc", 64'(input_fc), 64'd0);
            chk("idle_iweight", 64'(iweight_FC), 64'd0);
        end
        if (res_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 64'(res_data), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("res_idx", 64'(res_idx), 64'(e.idx));
                chk("res_data", 64'(res_data), 64'(e.data));
                chk("res_cycle", 64'(cyc), 64'(e.cyc));
                chk("res_done", 64'(done), 64'(e.idx == NO - 1));
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) monitor_cycle();
        end
    end

    task automatic push_exp(input int idx, input logic [31:0] data);
        exp_t e;
        e.idx  = idx;
        e.data = data;
        e.cyc  = base + longint'((idx + 1) * (NI + 1));
        exp_q.push_back(e);
    endtask

    // Reference dot products from the memory contents
    task automatic push_model();
        real s;
        for (int j = 0; j < NO; j++) begin
            s = 0.0;
            for (int k = 0; k < NI; k++) s = s + f2r(in_mem[k]) * f2r(w_mem[j*NI+k]);
            push_exp(j, r2f(s));
        end
    endtask

    task automatic begin_pass();
        base    = cyc + 1;
        pass_on = 1'b1;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_until_end(input bit pulse);
        while (cyc < base + T + 1) begin
            start = pulse && (cyc == base + 2 || cyc == base + T);
            @(negedge clk);
        end
        start = 1'b0;
        chk("results_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic load_directed(input bit zero_w);
        for (int k = 0; k < NI; k++) begin
            in_mem[k]    = 32'h3F80_0000;
            w_mem[k]     = zero_w ? 32'h0 : 32'h4000_0000;
            w_mem[NI+k]  = zero_w ? 32'h0 : r2f(real'(k + 1));
        end
    endtask

    task automatic load_random();
        for (int k = 0; k < NI; k++) in_mem[k] = r2f(real'(int'($urandom_range(0, 6)) - 2));
        for (int i = 0; i < NI * NO; i++) w_mem[i] = r2f(real'(int'($urandom_range(0, 6)) - 2));
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        load_directed(1'b0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        reset_check();
        rst    = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        // Directed pass with ignored start pulses in FEED and in LAST
        begin_pass();
        push_exp(0, 32'h4100_0000);
        push_exp(1, 32'h4120_0000);
        run_until_end(1'b1);
        repeat (2) @(negedge clk);

        // Abort mid-pass
        begin_pass();
        while (cyc < base + 3) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst     = 1'b0;
        pass_on = 1'b0;
        reset_check();
        repeat (4) @(negedge clk);

        // Restart reproduces the directed results
        begin_pass();
        push_exp(0, 32'h4100_0000);
        push_exp(1, 32'h4120_0000);
        run_until_end(1'b0);

        // Zero weights, then a back-to-back pass from the first IDLE cycle
        load_directed(1'b1);
        @(negedge clk);
        begin_pass();
        push_exp(0, 32'h0);
        push_exp(1, 32'h0);
        run_until_end(1'b0);
        begin_pass();
        push_exp(0, 32'h0);
        push_exp(1, 32'h0);
        run_until_end(1'b0);

        // Randomized passes against the dot-product model
        for (int r = 0; r < 8; r++) begin
            load_random();
            repeat ($urandom_range(0, 2)) @(negedge clk);
            begin_pass();
            push_model();
            run_until_end(r[0]);
        end

        repeat (3) @(negedge clk);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fc_feeder.md
# fc_feeder

Sequencer that drives one fully-connected processing element (fp32 multiply-accumulate with `start_newcol` clear) through a complete layer. It fetches input activations and weight rows from two synchronous-read memories, streams matched pairs into the PE, and clears the PE between output neurons. It also captures each neuron's accumulated sum as a one-cycle result pulse. It sits between the layer buffers and the FC PE, on the initiator side of the PE's feed interface.

## Interface

- `DATA_WIDTH`, 32: fp32 word width.
- `N_IN`, 16: input vector length (dot-product length), ≥1.
- `N_OUT`, 8: number of output neurons (weight rows), ≥1.
- `IN_AW`, clog2(N_IN) (min 1): input memory address width.
- `W_AW`, clog2(N_IN*N_OUT) (min 1): weight memory address width.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a layer pass; sampled only in IDLE.
- `busy`  out  1  high from the first CLEAR cycle through the LAST cycle.
- `done`  out  1  one-cycle pulse in the LAST cycle.
- `in_addr`  out  IN_AW  input memory read address.
- `in_data`  in  DATA_WIDTH  input memory data, 1-cycle read latency.
- `w_addr`  out  W_AW  weight memory read address, row-major `j*N_IN+k`.
- `w_data`  in  DATA_WIDTH  weight memory data, 1-cycle read latency.
- `input_fc`  out  DATA_WIDTH  activation to the PE.
- `iweight_FC`  out  DATA_WIDTH  weight to the PE.
- `start_newcol`  out  1  PE accumulator clear.
- `output_fc`  in  DATA_WIDTH  PE accumulated result (registered in the PE).
- `res_valid`  out  1  result strobe, one cycle per neuron.
- `res_data`  out  DATA_WIDTH  neuron sum, equal to `output_fc` while `res_valid` is high.
- `res_idx`  out  clog2(N_OUT) (min 1)  neuron index j of `res_data`.

## Operation

- States: IDLE, CLEAR, FEED, LAST.
- **IDLE**
  - `start_newcol`=1, which holds the PE at zero.
  - `input_fc`, `iweight_FC` = 0.
  - `start`=1 → CLEAR with j=0. A `start` seen in any other state is ignored.
- **CLEAR** (one cycle per neuron)
  - `start_newcol`=1; `input_fc`=`iweight_FC`=0.
  - Issues `in_addr`=0 and `w_addr`=j*N_IN.
  - Next state: FEED with k=0.
- **FEED** (N_IN cycles, k=0..N_IN-1)
  - `start_newcol`=0.
  - `input_fc`=`in_data` and `iweight_FC`=`w_data`, passed through combinationally; these are element k.
  - Issues the addresses for k+1 when k<N_IN-1.
  - After k=N_IN-1: if j<N_OUT-1, go to CLEAR with j+1; otherwise go to LAST.
- **Result capture**
  - In the cycle after the last FEED of neuron j (the next CLEAR, or LAST), `res_valid`=1, `res_data`=`output_fc`, `res_idx`=j.
  - Capture overlaps the next CLEAR. The PE clears only at the end of that cycle, so `output_fc` is still valid when sampled.
- **LAST**
  - Final result cycle; `done`=1, `busy`=1, `start_newcol`=1.
  - Next state: IDLE.
- **Address generation**
  - `w_addr` is a running counter incremented once per fetched element; no multiplier.
  - `in_addr` wraps to 0 at every CLEAR.
- **Values and reset**
  - The block only forwards data words; no arithmetic on them.
  - Reset values: state IDLE, `start_newcol`=1, and every other output 0 (`busy`, `done`, `res_valid`, `res_data`, `res_idx`, addresses, `input_fc`, `iweight_FC`).
  - `rst` mid-pass → IDLE on the next edge. No `res_valid`/`done` for the aborted pass, counters zeroed, PE held clear by `start_newcol`=1.
  - `rst` takes priority over `start` in the same cycle.

## Timing

- Cycle 0 is the first CLEAR, one cycle after `start` is sampled in IDLE.
- Neuron j occupies cycles j*(N_IN+1) through j*(N_IN+1)+N_IN.
- `res_valid` for neuron j occurs in cycle (j+1)*(N_IN+1).
- `done` occurs in cycle N_OUT*(N_IN+1), together with the last `res_valid`; return to IDLE follows.
- Earliest next start: `start` sampled in the first IDLE cycle → CLEAR in the following cycle. A `start` in the LAST cycle is dropped.
- Throughput: one MAC per cycle during FEED, plus one overhead cycle per neuron.

## Structure

- Shared package `fc_pkg`: state enum (IDLE/CLEAR/FEED/LAST) and the `DATA_WIDTH` default constant.
- Sub-module `fc_addr_gen`: k, j and weight-address counters with wrap and last-element flags.
- The FSM and result capture stay in `fc_feeder`.

## Test plan

Bench config: N_IN=4, N_OUT=2, memory models with 1-cycle read latency, and the FC PE connected.

- Inputs all 0x3F800000 (1.0); row 0 all 0x40000000 (2.0); row 1 = 1.0, 2.0, 3.0, 4.0 → `res_valid` in cycle 5 with `res_idx`=0 and `res_data`=0x41000000 (8.0); cycle 10 with `res_idx`=1, `res_data`=0x41200000 (10.0) and `done`=1.
- Address trace: `w_addr` presents 0..7 in order and `in_addr` presents 0..3 twice. `start_newcol` is high exactly in cycles 0 and 5, then high again in LAST/IDLE.
- `start` pulsed in cycles 2 and 10 → ignored. Exactly two results are produced, then IDLE.
- `rst` asserted in cycle 3 → no `res_valid`/`done`, and all outputs at reset values next cycle. A restart then reproduces 8.0 and 10.0.
- All weights 0x00000000 → both results 0x00000000. A second back-to-back pass started from IDLE gives identical timing.
